// File: rtl/sdr_req_responder.sv
// Two-client toggle-handshake responder: round-robin grant, one single-word
// transaction on the registered memory port, read data and ack returned to the client.
module sdr_req_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] FAIL_DATA      = 16'hFFFF
) (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic        c0_req,
  output logic        c0_ack,
  input  logic [23:0] c0_addr,
  input  logic [1:0]  c0_wr_sel,
  input  logic [15:0] c0_din,
  output logic [15:0] c0_dout,
  input  logic        c1_req,
  output logic        c1_ack,
  input  logic [23:0] c1_addr,
  input  logic [1:0]  c1_wr_sel,
  input  logic [15:0] c1_din,
  output logic [15:0] c1_dout,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_rdy,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant;
  logic [15:0] wait_cnt;

  logic        pend0;
  logic        pend1;
  logic        any_pend;
  logic        sel;
  logic        done_rdy;
  logic        done_to;
  logic        done;

  // Handshake: a client request is pending while its req differs from ack;
  // completion copies req onto ack, one transaction in flight at a time.
  always_comb begin
    pend0    = c0_req ^ c0_ack;
    pend1    = c1_req ^ c1_ack;
    any_pend = pend0 | pend1;
    sel      = (pend0 && pend1) ? ~last_grant : pend1;
    done_rdy = (state == ST_WAIT) && mem_rdy;
    done_to  = (state == ST_WAIT) && !mem_rdy && TO_EN && (wait_cnt == TO_LAST);
    done     = done_rdy | done_to;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_pend) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign dbg_state = state;

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      c0_ack      <= 1'b0;
      c1_ack      <= 1'b0;
      c0_dout     <= 16'd0;
      c1_dout     <= 16'd0;
      mem_req     <= 1'b0;
      mem_addr    <= 24'd0;
      mem_we      <= 1'b0;
      mem_be      <= 2'b00;
      mem_din     <= 16'd0;
      timeout_err <= 1'b0;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      wait_cnt    <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_pend) begin
            grant      <= sel;
            last_grant <= sel;
            mem_req    <= 1'b1;
            if (sel) begin
              mem_addr <= c1_addr;
              mem_din  <= c1_din;
              mem_we   <= |c1_wr_sel;
              mem_be   <= (|c1_wr_sel) ? c1_wr_sel : 2'b11;
            end else begin
              mem_addr <= c0_addr;
              mem_din  <= c0_din;
              mem_we   <= |c0_wr_sel;
              mem_be   <= (|c0_wr_sel) ? c0_wr_sel : 2'b11;
            end
          end
        end
        ST_ISSUE: begin
          mem_req  <= 1'b0;
          wait_cnt <= 16'd0;
        end
        ST_WAIT: begin
          if (done) begin
            // Writes leave the client's read data untouched.
            if (!mem_we) begin
              if (grant) c1_dout <= done_rdy ? mem_dout : FAIL_DATA;
              else       c0_dout <= done_rdy ? mem_dout : FAIL_DATA;
            end
            if (grant) c1_ack <= c1_req;
            else       c0_ack <= c0_req;
            if (done_to) timeout_err <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule
